// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports (a, b) and the single memory port shared
// by data_mem_arbiter.
//   slave  : arbiter view. Requests and mem_rdata in; grants, responses and
//            memory controls out.
//   master : environment view (requesters plus memory model), the mirror image.
// Requester signals per x in {a,b}:
//   x_req, x_we, x_addr, x_wdata  -> arbiter
//   x_gnt, x_rvalid, x_rdata, x_err <- arbiter
// Memory signals:
//   mem_we, mem_re, mem_addr, mem_wdata <- arbiter
//   mem_rdata (combinational read data) -> arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_gnt, a_rvalid, a_rdata, a_err,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// A request sampled in cycle N gives x_gnt plus the memory access in N+1 and
// the x_rvalid response (read data or write acknowledge) in N+2. Addresses at
// or above DEPTH are granted but never reach the memory; they answer with
// x_err=1 and x_rdata=0.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  data_mem_arbiter_if.slave (requesters a/b and memory port)
// Build option: DMEM_ARB_ROUND_ROBIN_EN -- when defined, a simultaneous
// request from IDLE goes to the requester not served last; otherwise A wins.
//
// state   | meaning
// IDLE    | no access in flight, memory controls low
// SERVE_A | A granted this cycle, its memory access is on the bus
// SERVE_B | B granted this cycle, its memory access is on the bus
module data_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_A = 2'd1, SERVE_B = 2'd2} state_t;

    state_t            state, state_nxt;
    logic              serve_a, serve_b, prefer_a;
    logic              sel_we, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              a_gnt_q, a_gnt_n, b_gnt_q, b_gnt_n;
    logic              a_rvalid_q, a_rvalid_n, b_rvalid_q, b_rvalid_n;
    logic              a_err_q, a_err_n, b_err_q, b_err_n;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_n, b_rdata_q, b_rdata_n;
    logic              mem_we_q, mem_we_n, mem_re_q, mem_re_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    // Current access targets an address outside the memory.
    logic              oor_q, oor_n;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_b;

    assign prefer_a = last_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (serve_a) begin
            last_b <= 1'b0;
        end else if (serve_b) begin
            last_b <= 1'b1;
        end
    end
`else
    assign prefer_a = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = IDLE;
        serve_a     = 1'b0;
        serve_b     = 1'b0;
        a_gnt_n     = 1'b0;
        b_gnt_n     = 1'b0;
        a_rvalid_n  = 1'b0;
        b_rvalid_n  = 1'b0;
        a_err_n     = 1'b0;
        b_err_n     = 1'b0;
        a_rdata_n   = a_rdata_q;
        b_rdata_n   = b_rdata_q;
        mem_we_n    = 1'b0;
        mem_re_n    = 1'b0;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        oor_n       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.a_req && (!bus.b_req || prefer_a)) begin
                    serve_a = 1'b1;
                end else if (bus.b_req) begin
                    serve_b = 1'b1;
                end
            end
            SERVE_A: begin
                // Respond to A; A's own request is masked so B gets a turn.
                a_rvalid_n = 1'b1;
                a_err_n    = oor_q;
                if (oor_q) begin
                    a_rdata_n = '0;
                end else if (mem_re_q) begin
                    a_rdata_n = bus.mem_rdata;
                end
                serve_b = bus.b_req;
            end
            SERVE_B: begin
                b_rvalid_n = 1'b1;
                b_err_n    = oor_q;
                if (oor_q) begin
                    b_rdata_n = '0;
                end else if (mem_re_q) begin
                    b_rdata_n = bus.mem_rdata;
                end
                serve_a = bus.a_req;
            end
            default: ;
        endcase

        if (serve_a) begin
            state_nxt = SERVE_A;
        end else if (serve_b) begin
            state_nxt = SERVE_B;
        end

        sel_we    = serve_b ? bus.b_we    : bus.a_we;
        sel_addr  = serve_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = serve_b ? bus.b_wdata : bus.a_wdata;
        in_range  = sel_addr < ADDR_W'(DEPTH);

        if (serve_a || serve_b) begin
            a_gnt_n     = serve_a;
            b_gnt_n     = serve_b;
            mem_we_n    = sel_we & in_range;
            mem_re_n    = ~sel_we & in_range;
            mem_addr_n  = sel_addr;
            mem_wdata_n = sel_wdata;
            oor_n       = ~in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oor_q       <= 1'b0;
        end else begin
            a_gnt_q     <= a_gnt_n;
            b_gnt_q     <= b_gnt_n;
            a_rvalid_q  <= a_rvalid_n;
            b_rvalid_q  <= b_rvalid_n;
            a_err_q     <= a_err_n;
            b_err_q     <= b_err_n;
            a_rdata_q   <= a_rdata_n;
            b_rdata_q   <= b_rdata_n;
            mem_we_q    <= mem_we_n;
            mem_re_q    <= mem_re_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            oor_q       <= oor_n;
        end
    end

    assign bus.a_gnt     = a_gnt_q;
    assign bus.b_gnt     = b_gnt_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_err     = a_err_q;
    assign bus.b_err     = b_err_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning requester and memory address width.
REQ-003 SHALL have parameter DEPTH, default 32, meaning number of valid memory words (addresses 0..DEPTH-1).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have per-requester x in {a,b}: x_req in 1 access request; x_we in 1 (1=write, 0=read); x_addr in ADDR_W word address; x_wdata in DATA_W write data.
REQ-006 SHALL have per-requester outputs: x_gnt out 1 access issued this cycle; x_rvalid out 1 response pulse; x_rdata out DATA_W read data; x_err out 1 out-of-range flag, valid with x_rvalid.
REQ-007 SHALL have memory-side ports: mem_we out 1; mem_re out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W (combinational read data).

Function
REQ-008 SHALL implement FSM states IDLE, SERVE_A, SERVE_B; all mem_* and x_gnt are registered.
REQ-009 IDLE: a_req only -> SERVE_A; b_req only -> SERVE_B; both -> per REQ-020/021; neither -> IDLE.
REQ-010 On entering SERVE_x: mem_addr<=x_addr, mem_wdata<=x_wdata, mem_we<=x_we, mem_re<=~x_we, x_gnt<=1 for exactly that one cycle.
REQ-011 Requester holds x_we/x_addr/x_wdata stable while x_req=1 and x_gnt=0; it drops or changes its request in the cycle after x_gnt.
REQ-012 In SERVE_x the served requester's x_req is masked; next state is SERVE_y if y_req=1, else IDLE (no back-to-back grant to same requester).
REQ-013 Latency: req sampled in cycle N -> x_gnt and memory access in N+1 -> x_rvalid in N+2.
REQ-014 Reads: x_rdata<=mem_rdata, x_rvalid<=1 at end of SERVE_x; x_rvalid is a one-cycle pulse; x_rdata holds until the next x response.
REQ-015 Writes: x_rvalid pulses in N+2 as write acknowledge; x_rdata unchanged.
REQ-016 Out-of-range (x_addr >= DEPTH): x_gnt still pulses, mem_we=mem_re=0 in that cycle, x_rvalid=1 and x_err=1 in N+2, x_rdata<=0.
REQ-017 x_err SHALL be 0 whenever x_rvalid=0 and for in-range responses.
REQ-018 mem_we and mem_re SHALL never be 1 together; mem_* are 0 in IDLE.
REQ-019 a_gnt and b_gnt SHALL never be 1 in the same cycle.

Configuration
REQ-020 Macro DMEM_ARB_ROUND_ROBIN_EN defined: IDLE with both requests grants the requester not served last (last-served register, resets to B so A wins first contest).
REQ-021 Macro undefined: IDLE with both requests always grants A; REQ-012 alternation still applies.

Reset
REQ-022 rst=1 at a clock edge SHALL set state=IDLE, last-served=B, and every output (x_gnt, x_rvalid, x_rdata, x_err, mem_we, mem_re, mem_addr, mem_wdata) to 0.
REQ-023 rst asserted during a SERVE cycle: that memory access completes (mem_* were already driven), but its x_rvalid/x_rdata response is suppressed (outputs 0).
REQ-024 Requests present while rst=1 SHALL be ignored; first grant no earlier than cycle after rst deasserts.

Verification
REQ-025 Reset then a_req read addr 1, memory word 1 = 0x40600000 -> a_gnt cycle 1, mem_re=1 mem_addr=1, a_rvalid cycle 2 a_rdata=0x40600000 a_err=0.
REQ-026 b_req write addr 20 data 0x3F800000, then b read addr 20 -> mem_we pulse with addr 20; read returns 0x3F800000.
REQ-027 a_req and b_req held together from reset, 4 accesses each -> grants strictly alternate A,B,A,B...; never both gnt; (RR: A first; fixed: A first).
REQ-028 a read addr 40 (DEPTH=32) -> a_gnt pulses, mem_re=0, mem_we=0, a_rvalid=1 a_err=1 a_rdata=0.
REQ-029 rst asserted in SERVE_A cycle of write addr 5 data 0x12345678 -> memory word 5 = 0x12345678, a_rvalid stays 0, all outputs 0 next cycle.
REQ-030 Fixed-priority build, a_req and b_req rise together after IDLE gap -> A granted first; RR build after last-served A -> B granted first.
